pwm_duty_decoder: RTL and testbench

//  Receive-side counterpart of the PWM modulator. The modulator's comparator drives
//  the line high while frame_counter < duty, so each frame carries duty high samples.

---
 rtl/pwm_duty_decoder.sv | 136 +++++++++++++
 tb/tb_pwm_duty_decoder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_duty_decoder.sv
// Recovers the duty word of a counter<duty PWM line, one result per frame of PERIOD clocks.
// Locks to the frame on the first rising edge and flags rises at unexpected frame positions.
module pwm_duty_decoder #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PERIOD      = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] duty_out,
  output logic             valid,
  output logic             sat,
  output logic             locked,
  output logic             err
);

  localparam int unsigned IDX_W     = $clog2(PERIOD);
  localparam int unsigned CNT_W     = WIDTH + 1;
  localparam int unsigned MAX_DUTY  = (2 ** WIDTH) - 1;
  localparam int unsigned FULL_DUTY = (PERIOD < MAX_DUTY) ? PERIOD : MAX_DUTY;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PERIOD - 1);

  typedef enum logic {
    SEARCH  = 1'b0,
    MEASURE = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_W-1:0]       hi_q, hi_d;
  logic [WIDTH-1:0]       duty_q, duty_d;
  logic                   sat_q, sat_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   locked_q, locked_d;

  logic             s;
  logic             rise;
  logic [CNT_W-1:0] n;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign n    = hi_q + CNT_W'(s);

  // State, counters, synchronizer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      sync_q   <= '0;
      s_d_q    <= 1'b0;
      idx_q    <= '0;
      hi_q     <= '0;
      duty_q   <= '0;
      sat_q    <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_d_q    <= s;
      idx_q    <= idx_d;
      hi_q     <= hi_d;
      duty_q   <= duty_d;
      sat_q    <= sat_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= locked_d;
    end
  end

  // Frame tracking and duty recovery
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hi_d    = hi_q;
    duty_d  = duty_q;
    sat_d   = sat_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (!en) begin
      state_d = SEARCH;
      idx_d   = '0;
      hi_d    = '0;
    end else begin
      unique case (state_q)
        SEARCH: begin
          if (rise) begin
            state_d = MEASURE;
            idx_d   = IDX_W'(1);
            hi_d    = CNT_W'(1);
          end else if (idx_q == LAST_IDX) begin
            // No edge for a whole frame: the line sits at a constant level
            valid_d = 1'b1;
            duty_d  = s ? WIDTH'(FULL_DUTY) : '0;
            sat_d   = s;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        MEASURE: begin
          if (rise && (idx_q != '0)) begin
            err_d = 1'b1;
            idx_d = IDX_W'(1);
            hi_d  = CNT_W'(1);
          end else if (idx_q == LAST_IDX) begin
            valid_d = 1'b1;
            duty_d  = (n > CNT_W'(MAX_DUTY)) ? WIDTH'(MAX_DUTY) : n[WIDTH-1:0];
            sat_d   = (n == CNT_W'(PERIOD));
            idx_d   = '0;
            hi_d    = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            hi_d  = n;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == MEASURE);
  end

  assign duty_out = duty_q;
  assign valid    = valid_q;
  assign sat      = sat_q;
  assign locked   = locked_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Drives pwm_duty_decoder from a counter<duty reference modulator and checks every
// reported duty against the high-sample count of the line history it covers.
module tb_pwm_duty_decoder;

  localparam int unsigned W   = 8;
  localparam int unsigned P   = 256;
  localparam int unsigned SS  = 2;
  localparam int          LAT = SS + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         pwm_in;
  logic [W-1:0] duty_out;
  logic         valid;
  logic         sat;
  logic         locked;
  logic         err;

  pwm_duty_decoder #(.WIDTH(W), .PERIOD(P), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pwm_in   (pwm_in),
    .duty_out (duty_out),
    .valid    (valid),
    .sat      (sat),
    .locked   (locked),
    .err      (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference modulator and line history
  int duty_mod, duty_next, mod_cnt, line_mode, force_at;
  bit hist [0:65535];

  // Observation bookkeeping
  int         nvalid = 0;
  int         nerr   = 0;
  int         last_v_cyc = 0;
  bit         prev_locked = 1'b0;
  bit         prev_valid  = 1'b0;
  bit         prev_err    = 1'b0;
  logic [W-1:0] prev_duty;
  logic       prev_sat;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs after the edge, check them, then drive the next line sample
  task automatic tick();
    int sum;
    int base;
    int ed;
    int es;
    bit ln;
    @(posedge clk);
    #1;
    cyc++;
    if (valid) begin
      base = cyc - LAT;
      if (prev_locked) begin
        sum = 0;
        for (int k = 0; k < int'(P); k++)
          if (base - k >= 0) sum += int'(hist[base - k]);
        ed = (sum > 255) ? 255 : sum;
        es = (sum == int'(P)) ? 1 : 0;
      end else begin
        ed = hist[base] ? 255 : 0;
        es = hist[base] ? 1 : 0;
      end
      chk("model_duty", 32'(duty_out), 32'(ed));
      chk("model_sat", 32'(sat), 32'(es));
      nvalid++;
      last_v_cyc = cyc;
    end else if (!rst) begin
      chk("hold_duty", 32'(duty_out), 32'(prev_duty));
      chk("hold_sat", 32'(sat), 32'(prev_sat));
    end
    if (prev_valid) chk("valid_pulse", 32'(valid), 32'(0));
    if (prev_err) chk("err_pulse", 32'(err), 32'(0));
    if (err) nerr++;
    prev_locked = locked;
    prev_valid  = valid;
    prev_err    = err;
    prev_duty   = duty_out;
    prev_sat    = sat;

    if (mod_cnt == 0) duty_mod = duty_next;
    case (line_mode)
      1:       ln = 1'b0;
      2:       ln = 1'b1;
      default: ln = (mod_cnt < duty_mod);
    endcase
    if (cyc == force_at) ln = 1'b1;
    pwm_in    = ln;
    hist[cyc] = ln;
    mod_cnt   = (mod_cnt + 1) % int'(P);
  endtask

  task automatic wait_valid(input int max, input string tag);
    int n0;
    bit ok;
    n0 = nvalid;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (nvalid != n0) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, 32'(ok), 32'(1));
  endtask

  task automatic wait_locked(input int max, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      tick();
      if (locked) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, 32'(ok), 32'(1));
  endtask

  initial begin
    int e0;
    int n0;
    int t;
    int t_prev;
    bit lk;

    rst = 1'b1;
    en = 1'b0;
    pwm_in = 1'b0;
    line_mode = 0;
    force_at = -1;
    duty_next = 8'h66;
    duty_mod = duty_next;
    mod_cnt = int'($urandom_range(0, 255));

    repeat (3) tick();
    chk("rst_duty", 32'(duty_out), 32'(0));
    chk("rst_valid", 32'(valid), 32'(0));
    chk("rst_sat", 32'(sat), 32'(0));
    chk("rst_locked", 32'(locked), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    rst = 1'b0;

    // Random frame phase before enabling
    repeat ($urandom_range(10, 300)) tick();
    chk("idle_locked", 32'(locked), 32'(0));
    chk("idle_nvalid", 32'(nvalid), 32'(0));

    // 1: steady duty 0x66
    en = 1'b1;
    wait_locked(600, "t1_lock");
    e0 = nerr;
    wait_valid(600, "t1_v0");
    chk("t1_duty", 32'(duty_out), 32'(8'h66));
    chk("t1_sat", 32'(sat), 32'(0));
    chk("t1_locked", 32'(locked), 32'(1));
    t_prev = last_v_cyc;
    for (int i = 0; i < 3; i++) begin
      wait_valid(300, "t1_vn");
      chk("t1_duty_n", 32'(duty_out), 32'(8'h66));
      chk("t1_locked_n", 32'(locked), 32'(1));
      chk("t1_period", 32'(last_v_cyc - t_prev), 32'(P));
      t_prev = last_v_cyc;
    end
    chk("t1_no_err", 32'(nerr - e0), 32'(0));

    // 2: duty change at a frame boundary (frame in progress still reports the old word)
    duty_next = 8'h54;
    wait_valid(300, "t2_old");
    chk("t2_old_duty", 32'(duty_out), 32'(8'h66));
    for (int i = 0; i < 2; i++) begin
      wait_valid(300, "t2_a");
      chk("t2_duty_54", 32'(duty_out), 32'(8'h54));
    end
    duty_next = 8'h61;
    wait_valid(300, "t2_b");
    chk("t2_duty_54_last", 32'(duty_out), 32'(8'h54));
    wait_valid(300, "t2_c");
    chk("t2_duty_61", 32'(duty_out), 32'(8'h61));
    chk("t2_no_err", 32'(nerr - e0), 32'(0));

    // 3: constant low (unlocked), then constant high
    en = 1'b0;
    tick();
    tick();
    line_mode = 1;
    en = 1'b1;
    tick();
    chk("t3_unlocked", 32'(locked), 32'(0));
    wait_valid(300, "t3_lo0");
    t_prev = last_v_cyc;
    chk("t3_lo_duty", 32'(duty_out), 32'(0));
    chk("t3_lo_sat", 32'(sat), 32'(0));
    chk("t3_lo_locked", 32'(locked), 32'(0));
    wait_valid(300, "t3_lo1");
    chk("t3_lo_duty1", 32'(duty_out), 32'(0));
    chk("t3_lo_locked1", 32'(locked), 32'(0));
    chk("t3_lo_period", 32'(last_v_cyc - t_prev), 32'(P));
    line_mode = 2;
    for (int i = 0; i < 2; i++) begin
      wait_valid(300, "t3_hi");
      chk("t3_hi_duty", 32'(duty_out), 32'(8'hFF));
      chk("t3_hi_sat", 32'(sat), 32'(1));
    end

    // 4: extreme duties 0xFF and 0x01
    duty_next = 8'hFF;
    line_mode = 0;
    en = 1'b0;
    tick();
    tick();
    en = 1'b1;
    wait_valid(600, "t4_settle");
    e0 = nerr;
    wait_valid(300, "t4_ff");
    chk("t4_ff_duty", 32'(duty_out), 32'(8'hFF));
    chk("t4_ff_sat", 32'(sat), 32'(0));
    chk("t4_ff_locked", 32'(locked), 32'(1));
    duty_next = 8'h01;
    wait_valid(300, "t4_ff_last");
    chk("t4_ff_last_duty", 32'(duty_out), 32'(8'hFF));
    t_prev = last_v_cyc;
    wait_valid(300, "t4_01");
    chk("t4_01_duty", 32'(duty_out), 32'(8'h01));
    chk("t4_01_sat", 32'(sat), 32'(0));
    chk("t4_01_period", 32'(last_v_cyc - t_prev), 32'(P));
    chk("t4_no_err", 32'(nerr - e0), 32'(0));

    // 5: extra rise at frame index 100 drops the frame; the modulator's next
    // frame-start rise then lands mid-frame and re-aligns with a second err
    duty_next = 8'h2C;
    wait_valid(300, "t5_pre");
    wait_valid(300, "t5_base");
    chk("t5_base_duty", 32'(duty_out), 32'(8'h2C));
    t = cyc;
    n0 = nvalid;
    e0 = nerr;
    force_at = t + 98;
    while (cyc < t + 101) tick();
    chk("t5_err_at_inject", 32'(err), 32'(1));
    while (cyc < t + 511) tick();
    chk("t5_frame_dropped", 32'(nvalid - n0), 32'(0));
    chk("t5_err_count", 32'(nerr - e0), 32'(2));
    tick();
    chk("t5_next_valid", 32'(valid), 32'(1));
    chk("t5_next_duty", 32'(duty_out), 32'(8'h2C));
    force_at = -1;

    // 6: reset mid-frame, disabled interval, then re-acquire at 0x94
    repeat ($urandom_range(50, 150)) tick();
    rst = 1'b1;
    en = 1'b0;
    tick();
    rst = 1'b0;
    chk("t6_rst_duty", 32'(duty_out), 32'(0));
    chk("t6_rst_valid", 32'(valid), 32'(0));
    chk("t6_rst_sat", 32'(sat), 32'(0));
    chk("t6_rst_locked", 32'(locked), 32'(0));
    chk("t6_rst_err", 32'(err), 32'(0));
    duty_next = 8'h94;
    n0 = nvalid;
    lk = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (locked) lk = 1'b1;
    end
    chk("t6_dis_nvalid", 32'(nvalid - n0), 32'(0));
    chk("t6_dis_locked", 32'(lk), 32'(0));
    en = 1'b1;
    n0 = nvalid;
    wait_locked(600, "t6_lock");
    chk("t6_no_early_valid", 32'(nvalid - n0), 32'(0));
    wait_valid(300, "t6_v");
    chk("t6_duty", 32'(duty_out), 32'(8'h94));
    chk("t6_sat", 32'(sat), 32'(0));
    chk("t6_locked", 32'(locked), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
